// File: rtl/cnt_seq_checker.sv
// Sequence checker for a 4-bit up/down/step counter. It predicts each counter value from the
// previous sample and its controls, then reports lock, mismatches, an error count and wraps.
module cnt_seq_checker #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_CNT_W = 8,
  parameter int unsigned LOCK_N    = 2
) (
  input  logic                 clk_i,
  input  logic                 nrst_i,
  input  logic [WIDTH-1:0]     cnt_i,
  input  logic                 step_i,
  input  logic                 down_i,
  input  logic                 adv_i,
  input  logic                 clr_i,
  output logic [WIDTH-1:0]     expected_o,
  output logic                 locked_o,
  output logic                 err_o,
  output logic                 err_sticky_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 wrap_o
);

  // LOCK_N is limited to 1..15, so a 4-bit good counter is enough.
  localparam int unsigned GoodW = 4;
  localparam logic [GoodW-1:0] LockNVal = GoodW'(LOCK_N);

  typedef enum logic [1:0] {StSync, StAcq, StLocked} state_e;

  state_e                 state_q, state_d;
  logic [GoodW-1:0]       good_q, good_d, good_inc;
  logic [WIDTH-1:0]       prev_cnt_q, prev_d_q, prev_d_d, d_mag;
  logic                   prev_adv_q, prev_down_q;
  logic                   locked_q, locked_d;
  logic                   err_q, err_d;
  logic                   wrap_q, wrap_d;
  logic                   err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]       expected;
  logic                   match, crossed, err_evt;

  // Signed step as a modulo-2**WIDTH addend.
  always_comb begin
    d_mag    = step_i ? WIDTH'(2) : WIDTH'(1);
    prev_d_d = down_i ? (~d_mag + WIDTH'(1)) : d_mag;
  end

  always_comb begin
    expected = prev_adv_q ? (prev_cnt_q + prev_d_q) : prev_cnt_q;
    match    = (cnt_i == expected);
    crossed  = prev_down_q ? (cnt_i > prev_cnt_q) : (cnt_i < prev_cnt_q);
    good_inc = good_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    locked_d = locked_q;
    wrap_d   = 1'b0;
    err_evt  = 1'b0;
    unique case (state_q)
      StSync: begin
        state_d  = StAcq;
        good_d   = '0;
        locked_d = 1'b0;
      end
      StAcq: begin
        wrap_d = match & prev_adv_q & crossed;
        if (match) begin
          if (good_inc == LockNVal) begin
            state_d  = StLocked;
            locked_d = 1'b1;
            good_d   = '0;
          end else begin
            good_d = good_inc;
          end
        end else begin
          good_d = '0;
        end
      end
      StLocked: begin
        wrap_d = match & prev_adv_q & crossed;
        if (!match) begin
          err_evt  = 1'b1;
          state_d  = StAcq;
          good_d   = '0;
          locked_d = 1'b0;
        end
      end
      default: begin
        state_d  = StSync;
        good_d   = '0;
        locked_d = 1'b0;
      end
    endcase
    err_d = err_evt;
  end

  // clr wins over a simultaneous error; the err pulse itself is unaffected.
  always_comb begin
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (clr_i) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end else if (err_evt) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q      <= StSync;
      good_q       <= '0;
      prev_cnt_q   <= '0;
      prev_d_q     <= '0;
      prev_adv_q   <= 1'b0;
      prev_down_q  <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      wrap_q       <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      prev_cnt_q   <= cnt_i;
      prev_d_q     <= prev_d_d;
      prev_adv_q   <= adv_i;
      prev_down_q  <= down_i;
      locked_q     <= locked_d;
      err_q        <= err_d;
      wrap_q       <= wrap_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign expected_o   = expected;
  assign locked_o     = locked_q;
  assign err_o        = err_q;
  assign err_sticky_o = err_sticky_q;
  assign err_cnt_o    = err_cnt_q;
  assign wrap_o       = wrap_q;

  // An error always drops lock, and a wrap only follows a correct transition.
  a_err_unlocks : assert property (@(posedge clk_i) disable iff (!nrst_i) err_o |-> !locked_o);
  a_wrap_no_err : assert property (@(posedge clk_i) disable iff (!nrst_i) wrap_o |-> !err_o);
  a_locked_state : assert property (@(posedge clk_i) disable iff (!nrst_i)
                                    locked_o == (state_q == StLocked));

endmodule
